// File: rtl/execute_pkg.sv
// execute_pkg: shared types, widths, flag positions and the single-cycle ALU for the execute stage.
package execute_pkg;
  localparam int WIDTH = 32;
  localparam int REG_BITS = 4;
  localparam int PC_INDEX = 15;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;
  typedef logic [WIDTH-1:0] regval_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ASR, OP_MOV, OP_MUL
  } operation_t;
  typedef enum logic [1:0] {ADJ_NONE, ADJ_ADD, ADJ_SHL} adjustment_t;
  typedef struct packed {
    regval_t result;
    logic c;
    logic v;
  } alu_t;
  function automatic alu_t alu_op(operation_t op, regval_t a, regval_t b, logic c_in, logic v_in);
    logic [WIDTH:0] wide;
    alu_t o;
    o = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        o.result = wide[WIDTH-1:0];
        o.c = wide[WIDTH];
        o.v = (a[WIDTH-1] == b[WIDTH-1]) && (o.result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + 1'b1;
        o.result = wide[WIDTH-1:0];
        o.c = wide[WIDTH];
        o.v = (a[WIDTH-1] != b[WIDTH-1]) && (o.result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: o.result = a & b;
      OP_OR:  o.result = a | b;
      OP_XOR: o.result = a ^ b;
      // The extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
      OP_SHL: begin
        wide = {1'b0, a} << b[4:0];
        o.result = wide[WIDTH-1:0];
        o.c = wide[WIDTH];
      end
      OP_SHR: begin
        wide = {a, 1'b0} >> b[4:0];
        o.result = wide[WIDTH:1];
        o.c = wide[0];
      end
      OP_ASR: begin
        wide = $signed({a, 1'b0}) >>> b[4:0];
        o.result = wide[WIDTH:1];
        o.c = wide[0];
      end
      OP_MOV: o = '{result: b, c: c_in, v: v_in};
      default: o = '{result: '0, c: c_in, v: v_in};
    endcase
    return o;
  endfunction
endpackage

// File: rtl/execute_mul.sv
// mul_iterative: shift-add multiplier; bit 0 is consumed on start, one further bit per busy cycle.
module mul_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
    end else if (start) begin
      acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      count <= CW'(WIDTH-1);
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count - 1'b1;
      busy <= count != CW'(1);
    end
  end
  assign done = busy && count == CW'(1);
  assign product = acc[WIDTH-1:0];
  assign overflow = |acc[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/execute.sv
// execute: ALU stage with CNVZ flags, registered result and bypass feedback.
// EXECUTE_MULTIPLY_EN enables the iterative MUL; otherwise MUL is flagged illegal.
module execute
  import execute_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_hold,
  input  logic [WIDTH-1:0]    in_pc,
  input  logic [WIDTH-1:0]    in_left_value,
  input  logic [WIDTH-1:0]    in_right_value,
  input  logic [WIDTH-1:0]    in_adjustment_value,
  input  operation_t          in_operation,
  input  adjustment_t         in_adjustment_operation,
  input  logic [REG_BITS-1:0] in_target_register,
  input  logic [REG_BITS-1:0] in_address_register,
  input  logic                in_is_writing_memory,
  input  logic                in_has_flushed,
  output logic                out_valid,
  input  logic                out_hold,
  output logic [WIDTH-1:0]    out_pc,
  output logic [WIDTH-1:0]    out_result,
  output logic [WIDTH-1:0]    out_store_value,
  output logic [REG_BITS-1:0] out_target_register,
  output logic [REG_BITS-1:0] out_address_register,
  output logic                out_is_writing_memory,
  output logic                out_has_flushed,
  output logic                out_illegal,
  output logic [3:0]          flags,
  output logic                fb_valid,
  output logic [REG_BITS-1:0] fb_register,
  output logic [WIDTH-1:0]    fb_value
);
  logic [WIDTH-1:0] b, result;
  logic is_mul, idle, accept, mul_start, load, illegal, c_new, v_new;
  alu_t alu;
  assign b = in_adjustment_operation == ADJ_ADD ? in_right_value + in_adjustment_value :
             in_adjustment_operation == ADJ_SHL ? in_right_value << in_adjustment_value[4:0] :
             in_right_value;
  assign is_mul = in_operation == OP_MUL;
  assign alu = alu_op(in_operation, in_left_value, b, flags[FLAG_C], flags[FLAG_V]);
  assign accept = idle && in_valid && !out_hold;
`ifdef EXECUTE_MULTIPLY_EN
  typedef enum logic [1:0] {IDLE, MULTIPLY, DONE} state_t;
  state_t state, state_next;
  logic mul_busy, mul_done, mul_overflow, finish;
  logic [WIDTH-1:0] product;
  mul_iterative #(.WIDTH(WIDTH)) u_mul (
    .clock(clock), .reset(reset), .start(mul_start), .a(in_left_value), .b(b),
    .busy(mul_busy), .done(mul_done), .product(product), .overflow(mul_overflow)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state == IDLE ? (mul_start ? MULTIPLY : IDLE) :
                 state == MULTIPLY ? (mul_done ? DONE : MULTIPLY) :
                 (out_hold ? DONE : IDLE);
  end
  assign idle = state == IDLE;
  assign mul_start = accept && is_mul;
  assign finish = state == DONE && !out_hold;
  assign load = (accept && !is_mul) || finish;
  assign illegal = 1'b0;
  assign result = finish ? product : alu.result;
  assign c_new = finish ? mul_overflow : alu.c;
  assign v_new = finish ? mul_overflow : alu.v;
`else
  assign idle = 1'b1;
  assign mul_start = 1'b0;
  assign load = accept;
  assign illegal = is_mul;
  assign result = alu.result;
  assign c_new = alu.c;
  assign v_new = alu.v;
`endif
  assign in_hold = in_valid && (out_hold || !idle || mul_start);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_result <= '0;
      out_store_value <= '0;
      out_target_register <= '0;
      out_address_register <= '0;
      out_is_writing_memory <= 1'b0;
      out_has_flushed <= 1'b0;
      out_illegal <= 1'b0;
      flags <= '0;
    end else if (!out_hold) begin
      out_valid <= load;
      if (load) begin
        out_pc <= in_pc;
        out_result <= result;
        out_store_value <= in_left_value;
        out_target_register <= in_target_register;
        out_address_register <= in_address_register;
        out_is_writing_memory <= in_is_writing_memory;
        out_has_flushed <= in_has_flushed;
        out_illegal <= illegal;
        if (!in_has_flushed && !illegal) begin
          flags[FLAG_C] <= c_new;
          flags[FLAG_N] <= result[WIDTH-1];
          flags[FLAG_V] <= v_new;
          flags[FLAG_Z] <= result == '0;
        end
      end
    end
  end
  assign fb_valid = out_valid && !out_is_writing_memory;
  assign fb_register = out_target_register;
  assign fb_value = out_result;
endmodule

// File: tb/tb_execute.sv
// tb_execute: random and directed checks of execute against an arithmetic reference model.
module tb_execute;
  import execute_pkg::*;
`ifdef EXECUTE_MULTIPLY_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_hold, out_hold = 1'b0;
  logic [31:0] in_pc = '0, in_left_value = '0, in_right_value = '0, in_adjustment_value = '0;
  operation_t in_operation = OP_ADD;
  adjustment_t in_adjustment_operation = ADJ_NONE;
  logic [3:0] in_target_register = '0, in_address_register = '0;
  logic in_is_writing_memory = 1'b0, in_has_flushed = 1'b0;
  logic out_valid, out_is_writing_memory, out_has_flushed, out_illegal, fb_valid;
  logic [31:0] out_pc, out_result, out_store_value, fb_value;
  logic [3:0] out_target_register, out_address_register, flags, fb_register;
  int total = 0, bad = 0;
  logic e_valid, e_wm, e_fl, e_ill;
  logic [31:0] e_pc, e_res, e_store;
  logic [3:0] e_tr, e_ar, e_flags;

  execute dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_hold(in_hold),
    .in_pc(in_pc), .in_left_value(in_left_value), .in_right_value(in_right_value),
    .in_adjustment_value(in_adjustment_value), .in_operation(in_operation),
    .in_adjustment_operation(in_adjustment_operation), .in_target_register(in_target_register),
    .in_address_register(in_address_register), .in_is_writing_memory(in_is_writing_memory),
    .in_has_flushed(in_has_flushed), .out_valid(out_valid), .out_hold(out_hold),
    .out_pc(out_pc), .out_result(out_result), .out_store_value(out_store_value),
    .out_target_register(out_target_register), .out_address_register(out_address_register),
    .out_is_writing_memory(out_is_writing_memory), .out_has_flushed(out_has_flushed),
    .out_illegal(out_illegal), .flags(flags), .fb_valid(fb_valid), .fb_register(fb_register),
    .fb_value(fb_value)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input operation_t op, input logic [31:0] a, rv, adj,
                                  input adjustment_t aop, input logic [3:0] fin,
                                  output logic [31:0] r, output logic [3:0] f, output logic ill);
    logic [31:0] b;
    logic [63:0] s;
    longint sa;
    int sh;
    logic c, v;
    b = aop == ADJ_ADD ? rv + adj : aop == ADJ_SHL ? rv << adj[4:0] : rv;
    sh = int'(b[4:0]);
    c = fin[3];
    v = fin[1];
    ill = 1'b0;
    r = '0;
    case (op)
      OP_ADD: begin
        s = {32'b0, a} + {32'b0, b};
        r = s[31:0];
        c = s[32];
        sa = longint'($signed(a)) + longint'($signed(b));
        v = sa != longint'($signed(r));
      end
      OP_SUB: begin
        r = a - b;
        c = a >= b;
        sa = longint'($signed(a)) - longint'($signed(b));
        v = sa != longint'($signed(r));
      end
      OP_AND: begin r = a & b; c = 0; v = 0; end
      OP_OR:  begin r = a | b; c = 0; v = 0; end
      OP_XOR: begin r = a ^ b; c = 0; v = 0; end
      OP_SHL: begin r = a << sh; c = sh == 0 ? 1'b0 : a[32-sh]; v = 0; end
      OP_SHR: begin r = a >> sh; c = sh == 0 ? 1'b0 : a[sh-1]; v = 0; end
      OP_ASR: begin r = $signed(a) >>> sh; c = sh == 0 ? 1'b0 : a[sh-1]; v = 0; end
      OP_MOV: r = b;
      default: begin
        s = {32'b0, a} * {32'b0, b};
        if (MUL_EN) begin
          r = s[31:0];
          c = |s[63:32];
          v = c;
        end else ill = 1'b1;
      end
    endcase
    f = {c, r[31], v, r == 32'd0};
  endfunction

  task automatic model_reset();
    {e_valid, e_wm, e_fl, e_ill} = '0;
    {e_pc, e_res, e_store, e_tr, e_ar, e_flags} = '0;
  endtask

  // Record the instruction currently on the inputs as landed in the output register.
  task automatic model_land();
    logic [31:0] r;
    logic [3:0] f;
    logic ill;
    ref_alu(in_operation, in_left_value, in_right_value, in_adjustment_value,
            in_adjustment_operation, e_flags, r, f, ill);
    e_valid = 1'b1;
    e_pc = in_pc;
    e_res = r;
    e_store = in_left_value;
    e_tr = in_target_register;
    e_ar = in_address_register;
    e_wm = in_is_writing_memory;
    e_fl = in_has_flushed;
    e_ill = ill;
    if (!in_has_flushed && !ill) e_flags = f;
  endtask

  task automatic check_out(string tag);
    check({tag, ".valid"}, out_valid, e_valid);
    check({tag, ".res"}, out_result, e_res);
    check({tag, ".flags"}, flags, e_flags);
    check({tag, ".ill"}, out_illegal, e_ill);
    check({tag, ".fl"}, out_has_flushed, e_fl);
    check({tag, ".pc"}, out_pc, e_pc);
    check({tag, ".store"}, out_store_value, e_store);
    check({tag, ".regs"}, {out_target_register, out_address_register, out_is_writing_memory},
          {e_tr, e_ar, e_wm});
    check({tag, ".fb"}, {fb_valid, fb_register, fb_value}, {e_valid && !e_wm, e_tr, e_res});
  endtask

  task automatic drive(operation_t op, logic [31:0] a, rv, adj, adjustment_t aop,
                       logic fl, logic wm, logic v);
    in_operation = op;
    in_left_value = a;
    in_right_value = rv;
    in_adjustment_value = adj;
    in_adjustment_operation = aop;
    in_has_flushed = fl;
    in_is_writing_memory = wm;
    in_valid = v;
    in_pc = $urandom;
    in_target_register = 4'($urandom);
    in_address_register = 4'($urandom);
  endtask

  // One cycle with the pipeline idle: check in_hold, clock, update model, check outputs.
  task automatic apply(string tag, operation_t op, logic [31:0] a, rv, adj, adjustment_t aop,
                       logic fl, logic wm, logic v, logic hold);
    drive(op, a, rv, adj, aop, fl, wm, v);
    out_hold = hold;
    #1;
    check({tag, ".in_hold"}, in_hold, v && hold);
    @(posedge clock);
    #1;
    if (!hold) begin
      if (v) model_land();
      else e_valid = 1'b0;
    end
    check_out(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst.async", {out_valid, flags, out_illegal, out_has_flushed, out_result}, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_out("rst");
  endtask

`ifdef EXECUTE_MULTIPLY_EN
  // Runs a MUL, optionally holding the write stage for 3 cycles once it is ready.
  task automatic run_mul(string tag, logic [31:0] a, rv, logic hold_done);
    int holds = 0, edges = 0;
    drive(OP_MUL, a, rv, 32'd0, ADJ_NONE, 1'b0, 1'b0, 1'b1);
    out_hold = 1'b0;
    while (edges < 80) begin
      if (hold_done && edges == 32) begin
        out_hold = 1'b1;
        repeat (3) begin
          #1;
          check({tag, ".hold_ih"}, in_hold, 1'b1);
          @(posedge clock);
          #1;
          check({tag, ".hold_ov"}, out_valid, 1'b0);
        end
        out_hold = 1'b0;
      end
      #1;
      if (in_hold) holds++;
      @(posedge clock);
      #1;
      edges++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check({tag, ".edges"}, edges, 33);
    check({tag, ".in_hold_cycles"}, holds, 33);
    model_land();
    check_out(tag);
  endtask
`endif

  initial begin
    logic [31:0] a, rv;
    logic [3:0] f0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_out("reset");
    check("reset.in_hold", in_hold, 1'b0);
    apply("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    check("add_ovf.res_k", out_result, 32'h80000000);
    check("add_ovf.flags_k", flags, 4'b0110);
    apply("sub_z", OP_SUB, 32'd5, 32'd5, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    check("sub_z.flags_k", flags, 4'b1001);
    check("sub_z.fb_k", {fb_valid, fb_register}, {1'b1, in_target_register});
    apply("shl_fl", OP_ADD, 32'd1, 32'd3, 32'd2, ADJ_SHL, 1, 0, 1, 0);
    check("shl_fl.res_k", out_result, 32'd13);
    check("shl_fl.flags_k", {flags, out_has_flushed}, {4'b1001, 1'b1});
`ifdef EXECUTE_MULTIPLY_EN
    run_mul("mul", 32'h00010000, 32'h00010000, 1'b0);
    check("mul.k", {out_result, flags, out_illegal}, {32'h0, 4'b1011, 1'b0});
    run_mul("mul_hold", 32'd3, 32'd5, 1'b1);
    check("mul_hold.k", out_result, 32'd15);
`else
    f0 = flags;
    apply("mul_ill", OP_MUL, 32'h00010000, 32'h00010000, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    check("mul_ill.k", {out_result, out_illegal, flags}, {32'h0, 1'b1, f0});
`endif
    apply("pre_hold", OP_XOR, 32'hF0F0, 32'hFF00, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    drive(OP_OR, 32'h1234, 32'h4321, 32'h0, ADJ_NONE, 0, 1, 1);
    out_hold = 1'b1;
    repeat (3) begin
      #1;
      check("hold.in_hold", in_hold, 1'b1);
      @(posedge clock);
      #1;
      check_out("hold");
    end
    out_hold = 1'b0;
    #1;
    check("hold.release_ih", in_hold, 1'b0);
    @(posedge clock);
    #1;
    model_land();
    check_out("hold_land");
    check("hold_land.k", {out_result, fb_valid}, {32'h5335, 1'b0});
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      rv = $urandom_range(3, 0) == 0 ? a : $urandom;
      apply("rnd", operation_t'($urandom_range(MUL_EN ? 8 : 9, 0)), a, rv,
            $urandom_range(1, 0) ? $urandom : 32'($urandom_range(31, 0)),
            adjustment_t'($urandom_range(2, 0)), $urandom_range(7, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(7, 0) != 0, $urandom_range(4, 0) == 0);
    end
`ifdef EXECUTE_MULTIPLY_EN
    drive(OP_MUL, 32'd7, 32'd9, 32'h0, ADJ_NONE, 0, 0, 1);
    out_hold = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    in_valid = 1'b0;
`else
    apply("pre_rst", OP_SUB, 32'd1, 32'd2, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    in_valid = 1'b0;
`endif
    do_reset();
    apply("after_rst_idle", OP_ADD, 32'd0, 32'd0, 32'h0, ADJ_NONE, 0, 0, 0, 0);
    apply("after_rst", OP_ADD, 32'd2, 32'd2, 32'h0, ADJ_NONE, 0, 0, 1, 0);
    check("after_rst.k", {out_valid, out_result, flags}, {1'b1, 32'd4, 4'b0000});
    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/execute.md
# execute

Third pipeline stage: consumes the operand bundle produced by the read stage, computes the ALU result and CNVZ flags, and registers the result for the write stage. It supplies the current flags back to the read stage for predicated issue, and a registered forwarding value (execute feedback) for operand bypass. Multiplies are iterative and stall the pipeline through the flow-control hold.

## Interface
- WIDTH, 32, register value width (regval_t)
- REG_BITS, 4, register index width; index 15 is PC
- clock  in  1  stage clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  read stage holds a valid instruction
- in_hold  out  1  upstream must hold its output register
- in_pc, in_left_value, in_right_value, in_adjustment_value  in  WIDTH  operands from read
- in_operation  in  operation_t  ALU operation
- in_adjustment_operation  in  adjustment_t  right-operand pre-adjust
- in_target_register, in_address_register  in  REG_BITS  destination / address register
- in_is_writing_memory, in_has_flushed  in  1  pass-through qualifiers
- out_valid  out  1  result register valid
- out_hold  in  1  write stage stall
- out_pc, out_result, out_store_value  out  WIDTH  registered pc, ALU result, store data (= in_left_value)
- out_target_register, out_address_register  out  REG_BITS  pass-through
- out_is_writing_memory, out_has_flushed, out_illegal  out  1  qualifiers
- flags  out  4  current CNVZ: [3]=C [2]=N [1]=V [0]=Z
- fb_valid  out  1  = out_valid and not out_is_writing_memory
- fb_register  out  REG_BITS  = out_target_register
- fb_value  out  WIDTH  = out_result

## Operation
- Right operand b: ADJ_NONE → in_right_value; ADJ_ADD → in_right_value + in_adjustment_value; ADJ_SHL → in_right_value << in_adjustment_value[4:0]. Truncated to WIDTH.
- ADD/SUB: a±b; C = carry out (SUB: C=1 when no borrow); V = signed overflow.
- AND/OR/XOR: C=V=0. SHL/SHR/ASR by b[4:0]: C = last bit shifted out (0 when amount 0), V=0.
- MOV: result = b, C and V unchanged.
- MUL: low WIDTH bits of a*b; C=V=1 when high WIDTH bits nonzero.
- N=result[WIDTH-1], Z=(result==0) for every flag-writing op.
- Flags update only when an instruction is accepted, has in_has_flushed=0, and is not illegal.
- FSM: IDLE, MULTIPLY, DONE.
  - IDLE: single-cycle op accepted when in_valid and not out_hold. MUL accepted → MULTIPLY, load multiplicand/multiplier, count=WIDTH-1.
  - MULTIPLY: shift-add one bit per cycle; count 0 → DONE.
  - DONE: if not out_hold, load output register, flags update → IDLE.
- in_hold = in_valid and (out_hold or state≠IDLE or MUL accepted this cycle).
- No accepted instruction (in_valid=0) and not out_hold → out_valid=0 next edge.
- out_hold=1: all out_* and fb_* frozen.

## Timing
- Reset: state IDLE, out_valid=0, flags=0, out_illegal=0, out_has_flushed=0, all data outputs 0.
- Single-cycle ops: result at out_* one edge after acceptance.
- MUL: in_hold high WIDTH+1 cycles from acceptance; out_valid on edge WIDTH+1 (33 at default).
- out_hold during DONE: stays DONE, in_hold stays high.
- Reset mid-MULTIPLY: abandons product, returns IDLE, no output.
- fb_* are registered; no combinational path from in_* to fb_*.

## Configuration
- EXECUTE_MULTIPLY_EN defined: MUL implemented as above.
- Undefined: MUL is single-cycle, result 0, out_illegal=1, flags unchanged; MULTIPLY/DONE states absent.

## Structure
- Shared package: operation_t, adjustment_t, regval_t, flag bit positions, PC index.
- Sub-module mul_iterative (start, operands, busy, done, product, overflow), instantiated only under EXECUTE_MULTIPLY_EN.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → out_result 0x80000000 next edge, flags C=0 N=1 V=1 Z=0.
- SUB 5 - 5 → result 0, flags C=1 N=0 V=0 Z=1; fb_valid=1, fb_register = target.
- ADD left=1, right=3, ADJ_SHL adj=2 → result 13; with in_has_flushed=1 flags unchanged, out_has_flushed=1.
- MUL 0x00010000 * 0x00010000 → in_hold high 33 cycles, result 0, C=V=1, Z=1; without EXECUTE_MULTIPLY_EN → result 0, out_illegal=1 after one cycle.
- out_hold held 3 cycles with valid input → out_* unchanged, in_hold=1, instruction lands on release.
- reset asserted 10 cycles into MUL → out_valid=0, flags=0, next ADD 2+2 → 4 one cycle after acceptance.
